riscv_lsu: RTL and testbench



---
 rtl/riscv_pkg.sv | 12 +
 rtl/lsu_load_extend.sv | 31 +++
 rtl/riscv_lsu.sv | 133 +++++++++++++
 tb/tb_riscv_lsu.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store size codes (funct3 encoding) and the LSU state type.
package riscv_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic {IDLE, WAIT} lsu_state_t;

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/halfword of a bus read word and sign/zero-extends it.
module lsu_load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] core_rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = mem_rd[7:0];
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = offset[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (size)
            LDST_B:  core_rd = {{24{byte_sel[7]}}, byte_sel};
            LDST_BU: core_rd = {24'd0, byte_sel};
            LDST_H:  core_rd = {{16{half_sel[15]}}, half_sel};
            LDST_HU: core_rd = {16'd0, half_sel};
            default: core_rd = mem_rd;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: core access -> byte-enabled word bus with ready handshake and stall.
// Optional LSU_MISALIGN_CHECK_EN adds misalign_o and suppresses misaligned requests.
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        bus_err_o,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    lsu_state_t      state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      size_q;
    logic [1:0]      off_q;
    logic [31:0]     ext_rd;
    logic            is_byte, is_half, misalign;
    logic            req, stall, err;
    logic [31:0]     rd;
    logic [3:0]      be;

    assign is_byte = (core_size_i == LDST_B) || (core_size_i == LDST_BU);
    assign is_half = (core_size_i == LDST_H) || (core_size_i == LDST_HU);

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = core_req_i && ((is_half && core_addr_i[0]) ||
                      (!is_byte && !is_half && core_addr_i[1:0] != 2'd0));
    assign misalign_o = !rst_i && (state == IDLE) && misalign;
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        if (is_byte)      be = 4'b0001 << core_addr_i[1:0];
        else if (is_half) be = core_addr_i[1] ? 4'b1100 : 4'b0011;
        else              be = 4'b1111;
    end

    assign mem_addr_o = core_addr_i;
    assign mem_wd_o   = is_byte ? {4{core_wd_i[7:0]}} :
                        is_half ? {2{core_wd_i[15:0]}} : core_wd_i;

    lsu_load_extend u_ext (
        .mem_rd  (mem_rd_i),
        .size    (size_q),
        .offset  (off_q),
        .core_rd (ext_rd)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req        = 1'b0;
        stall      = 1'b0;
        err        = 1'b0;
        rd         = 32'd0;
        case (state)
            IDLE: begin
                if (core_req_i && !misalign) begin
                    req        = 1'b1;
                    stall      = 1'b1;
                    state_next = WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                req   = 1'b1;
                stall = !mem_ready_i;
                if (mem_ready_i) begin
                    rd         = ext_rd;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (WAIT_LIMIT != 0) begin
                    // The cycle in which the count would hit the limit is the abort cycle.
                    if ((cnt + 1'b1) == LIMIT) begin
                        stall      = 1'b0;
                        err        = 1'b1;
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req_o    = !rst_i && req;
    assign mem_we_o     = !rst_i && req && core_we_i;
    assign core_stall_o = !rst_i && stall;
    assign bus_err_o    = !rst_i && err;
    assign mem_be_o     = rst_i ? 4'd0 : be;
    assign core_rd_o    = rst_i ? 32'd0 : rd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            size_q <= LDST_W;
            off_q  <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && core_req_i) begin
                size_q <= core_size_i;
                off_q  <= core_addr_i[1:0];
            end
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed-vector bench for riscv_lsu: stores, loads, wait states, timeout, reset abort.
module tb_riscv_lsu;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, req, we, mem_ready;
    logic [2:0]  size;
    logic [31:0] addr, wd, mem_rd;
    logic [31:0] core_rd, mem_addr, mem_wd;
    logic        stall, bus_err, mem_req, mem_we;
    logic [3:0]  mem_be;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    riscv_lsu #(.WAIT_LIMIT(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .core_req_i   (req),
        .core_we_i    (we),
        .core_size_i  (size),
        .core_addr_i  (addr),
        .core_wd_i    (wd),
        .core_rd_o    (core_rd),
        .core_stall_o (stall),
        .bus_err_o    (bus_err),
`ifdef LSU_MISALIGN_CHECK_EN
        .misalign_o   (misalign),
`endif
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wd_o     (mem_wd),
        .mem_rd_i     (mem_rd),
        .mem_ready_i  (mem_ready)
    );

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; we = 1'b1; size = LDST_W; addr = 32'h104;
        wd = 32'h12345678; mem_ready = 1'b1; mem_rd = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_we, stall, bus_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000", {mem_req, mem_we, stall, bus_err});
        end
        vectors++;
        if (mem_be !== 4'd0 || core_rd !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: be=%h rd=%h want 0/0", mem_be, core_rd);
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, stall, bus_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %b want 000", {mem_req, stall, bus_err});
        end
    endtask

    task automatic test_stores();
        vec_t v [4];
        v[0] = '{LDST_W, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
        v[1] = '{LDST_B, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5};
        v[2] = '{LDST_H, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD};
        v[3] = '{LDST_B, 32'h100, 32'h00000012, 4'b0001, 32'h12121212};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            req = 1'b1; we = 1'b1; size = v[i].size; addr = v[i].addr;
            wd = v[i].data; mem_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if ({mem_req, mem_we, stall, mem_be} !== {3'b111, v[i].be} || mem_wd !== v[i].exp
                || mem_addr !== v[i].addr) begin
                miscompares++;
                $display("FAIL store%0d_req: req/we/stall/be=%b wd=%h addr=%h want %b %h %h", i,
                         {mem_req, mem_we, stall, mem_be}, mem_wd, mem_addr,
                         {3'b111, v[i].be}, v[i].exp, v[i].addr);
            end
            @(posedge clk); #1;
            mem_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if ({mem_req, mem_we, stall} !== 3'b110) begin
                miscompares++;
                $display("FAIL store%0d_ready: req/we/stall=%b want 110", i, {mem_req, mem_we, stall});
            end
            @(posedge clk); #1;
            req = 1'b0; mem_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if ({mem_req, stall} !== 2'b00) begin
                miscompares++;
                $display("FAIL store%0d_done: req/stall=%b want 00", i, {mem_req, stall});
            end
        end
    endtask

    task automatic test_loads();
        vec_t v [7];
        v[0] = '{LDST_B,  32'h102, 32'h0080FF00, 4'b0100, 32'hFFFFFF80};
        v[1] = '{LDST_BU, 32'h102, 32'h0080FF00, 4'b0100, 32'h00000080};
        v[2] = '{LDST_H,  32'h102, 32'h80011234, 4'b1100, 32'hFFFF8001};
        v[3] = '{LDST_HU, 32'h102, 32'h80011234, 4'b1100, 32'h00008001};
        v[4] = '{LDST_W,  32'h100, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};
        v[5] = '{LDST_B,  32'h101, 32'h0080FF00, 4'b0010, 32'hFFFFFFFF};
        v[6] = '{LDST_H,  32'h100, 32'h80017FFE, 4'b0011, 32'h00007FFE};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            req = 1'b1; we = 1'b0; size = v[i].size; addr = v[i].addr;
            mem_rd = v[i].data; mem_ready = 1'b0;
            @(negedge clk);
            vectors++;
            if ({mem_req, mem_we, stall, mem_be} !== {3'b101, v[i].be}) begin
                miscompares++;
                $display("FAIL load%0d_req: req/we/stall/be=%b want %b", i,
                         {mem_req, mem_we, stall, mem_be}, {3'b101, v[i].be});
            end
            // Extension must come from the size/offset captured at request time.
            @(posedge clk); #1;
            mem_ready = 1'b1; size = LDST_W; addr = 32'h200;
            @(negedge clk);
            vectors++;
            if (stall !== 1'b0 || core_rd !== v[i].exp) begin
                miscompares++;
                $display("FAIL load%0d_data: stall=%b rd=%h want 0 %h", i, stall, core_rd, v[i].exp);
            end
            @(posedge clk); #1;
            req = 1'b0; mem_ready = 1'b0;
        end
    endtask

    task automatic test_delayed_ready();
        logic [4:0] stall_hist;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; size = LDST_BU; addr = 32'h103;
        mem_rd = 32'hAB000000; mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            stall_hist[c] = stall & mem_req;
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall_hist !== 5'b11111) begin
            miscompares++;
            $display("FAIL delayed_stall: hist=%b want 11111", stall_hist);
        end
        vectors++;
        if (stall !== 1'b0 || core_rd !== 32'h000000AB) begin
            miscompares++;
            $display("FAIL delayed_data: stall=%b rd=%h want 0 000000ab", stall, core_rd);
        end
        @(posedge clk); #1;
        req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int err_cycle = -1;
        logic stall_at_err = 1'b1;
        logic [31:0] rd_at_err = 32'hFFFFFFFF;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h200;
        mem_rd = 32'h55AA55AA; mem_ready = 1'b0;
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus_err === 1'b1) begin
                err_cycle = c; stall_at_err = stall; rd_at_err = core_rd;
                break;
            end
        end
        vectors++;
        if (err_cycle != 16) begin
            miscompares++;
            $display("FAIL timeout_cycle: bus_err at %0d want 16", err_cycle);
        end
        vectors++;
        if (stall_at_err !== 1'b0 || rd_at_err !== 32'd0) begin
            miscompares++;
            $display("FAIL timeout_outputs: stall=%b rd=%h want 0 0", stall_at_err, rd_at_err);
        end
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus_err, mem_req, stall} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_after: err/req/stall=%b want 000", {bus_err, mem_req, stall});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a, rd_b;
        logic s0, s2;
        // Ready held high throughout: it must be ignored in each request cycle.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h300;
        mem_rd = 32'h11112222; mem_ready = 1'b1;
        @(negedge clk); s0 = stall;
        @(posedge clk); #1;
        @(negedge clk); rd_a = core_rd;
        vectors++;
        if (s0 !== 1'b1 || stall !== 1'b0 || rd_a !== 32'h11112222) begin
            miscompares++;
            $display("FAIL b2b_first: stall %b->%b rd=%h want 1->0 11112222", s0, stall, rd_a);
        end
        @(posedge clk); #1;
        size = LDST_HU; addr = 32'h306; mem_rd = 32'hBEEF0000;
        @(negedge clk); s2 = stall;
        vectors++;
        if (s2 !== 1'b1 || mem_req !== 1'b1 || mem_be !== 4'b1100) begin
            miscompares++;
            $display("FAIL b2b_second_req: stall=%b req=%b be=%b want 1 1 1100", s2, mem_req, mem_be);
        end
        @(posedge clk); #1;
        @(negedge clk); rd_b = core_rd;
        vectors++;
        if (stall !== 1'b0 || rd_b !== 32'h0000BEEF) begin
            miscompares++;
            $display("FAIL b2b_second_data: stall=%b rd=%h want 0 0000beef", stall, rd_b);
        end
        @(posedge clk); #1;
        req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; size = LDST_W; addr = 32'h400; wd = 32'h0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_we, stall} !== 3'b111) begin
            miscompares++;
            $display("FAIL rst_wait_pre: req/we/stall=%b want 111", {mem_req, mem_we, stall});
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_we, stall, bus_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_wait_hold: req/we/stall/err=%b want 0000", {mem_req, mem_we, stall, bus_err});
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, stall, bus_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_wait_idle: req/stall/err=%b want 000", {mem_req, stall, bus_err});
        end
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wait_restart: stall=%b want 1", stall);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        req = 1'b0; mem_ready = 1'b0;
    endtask

`ifdef LSU_MISALIGN_CHECK_EN
    task automatic test_misalign();
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; size = LDST_W; addr = 32'h101; mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            vectors++;
            if ({misalign, mem_req, stall} !== 3'b100 || core_rd !== 32'd0) begin
                miscompares++;
                $display("FAIL misalign_lw%0d: mis/req/stall=%b rd=%h want 100 0", c,
                         {misalign, mem_req, stall}, core_rd);
            end
            @(posedge clk); #1;
        end
        size = LDST_H; addr = 32'h101;
        @(negedge clk);
        vectors++;
        if ({misalign, mem_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL misalign_lh: mis/req=%b want 10", {misalign, mem_req});
        end
        @(posedge clk); #1;
        addr = 32'h102;
        @(negedge clk);
        vectors++;
        if ({misalign, mem_req, stall} !== 3'b011) begin
            miscompares++;
            $display("FAIL aligned_lh: mis/req/stall=%b want 011", {misalign, mem_req, stall});
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; mem_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_back_to_back();
        test_delayed_ready();
        test_timeout();
        test_reset_mid_wait();
`ifdef LSU_MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
